// File: rtl/data_memory_pkg.sv
// Shared operation codes, FSM state encoding and small decode helpers
// for the byte-lane-aware data memory unit.
package data_memory_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_EXECUTE = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: legal = 1'b1;
      OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR:                 legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/data_memory_unit_byte_lane.sv
// Combinational big-endian lane steering: load extraction/extension and
// the merged word written back for partial stores.
module byte_lane_unit
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [3:0]  operation,
  input  logic [31:0] write_data,
  input  logic [31:0] merge_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh_lo_s;
  logic [4:0]  sh_hi_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Shift amounts 8a and 8(3-a); for a 2-bit lane, 3-a is simply ~a.
  always_comb begin
    sh_lo_s = {lane, 3'b000};
    sh_hi_s = {~lane, 3'b000};
    byte_s  = 8'(word >> sh_hi_s);
    half_s  = lane[1] ? word[15:0] : word[31:16];
  end

  // Load result selection.
  always_comb begin
    load_data = 32'h0000_0000;
    case (operation)
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data = {24'h00_0000, byte_s};
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data = {16'h0000, half_s};
      OP_LW:   load_data = word;
      OP_LWL:  load_data = (word << sh_lo_s) | (merge_data & ~(32'hFFFF_FFFF << sh_lo_s));
      OP_LWR:  load_data = (word >> sh_hi_s) | (merge_data & ~(32'hFFFF_FFFF >> sh_hi_s));
      default: load_data = 32'h0000_0000;
    endcase
  end

  // New word for stores; SWR at lane 3 keeps nothing of the old word.
  always_comb begin
    store_word = word;
    case (operation)
      OP_SB:   store_word = (word & ~(32'hFF00_0000 >> sh_lo_s))
                          | ({24'h00_0000, write_data[7:0]} << sh_hi_s);
      OP_SH:   store_word = lane[1] ? {word[31:16], write_data[15:0]}
                                    : {write_data[15:0], word[15:0]};
      OP_SW:   store_word = write_data;
      OP_SWL:  store_word = (word & ~(32'hFFFF_FFFF >> sh_lo_s)) | (write_data >> sh_lo_s);
      OP_SWR:  store_word = (lane == 2'd3) ? write_data
                          : ((word & (32'hFFFF_FFFF >> (sh_lo_s + 5'd8))) | (write_data << sh_hi_s));
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Serialised load/store data memory with configurable wait states, byte-lane
// handling and error flagging for misaligned, out-of-range or illegal accesses.
module data_memory_unit
  import data_memory_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        request,
  output logic        ready,
  input  logic [3:0]  operation,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [31:0] merge_data,
  output logic        response_valid,
  output logic [31:0] read_data,
  output logic        error
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] storage [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdata_q, mdata_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        response_valid_q, response_valid_d;
  logic [31:0] read_data_q, read_data_d;
  logic        error_q, error_d;

  logic             ready_s;
  logic             err_s;
  logic             we_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      word_s;
  logic [31:0]      load_data_s;
  logic [31:0]      store_word_s;

  assign idx_s  = addr_q[IDX_W+1:2];
  assign word_s = storage[idx_s];

  byte_lane_unit u_lanes (
    .word       (word_s),
    .lane       (addr_q[1:0]),
    .operation  (op_q),
    .write_data (wdata_q),
    .merge_data (mdata_q),
    .load_data  (load_data_s),
    .store_word (store_word_s)
  );

  // Error classification of the captured access.
  always_comb begin
    err_s = 1'b0;
    if (!is_legal_op(op_q)) begin
      err_s = 1'b1;
    end else if ({2'b00, addr_q[31:2]} >= 32'(DEPTH)) begin
      err_s = 1'b1;
    end else begin
      case (op_q)
        OP_LH, OP_LHU, OP_SH: err_s = addr_q[0];
        OP_LW, OP_SW:         err_s = (addr_q[1:0] != 2'd0);
        default:              err_s = 1'b0;
      endcase
    end
  end

  // The response cycle still counts as busy so that ready drops for LATENCY+3 cycles.
  always_comb begin
    ready_s = (state_q == ST_IDLE) && !response_valid_q;
    we_s    = (state_q == ST_EXECUTE) && is_store(op_q) && !err_s;
  end

  // FSM, capture and output next-state logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    mdata_d          = mdata_q;
    result_d         = result_q;
    err_d            = err_q;
    response_valid_d = 1'b0;
    read_data_d      = 32'h0000_0000;
    error_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request && ready_s) begin
          op_d    = operation;
          addr_d  = address;
          wdata_d = write_data;
          mdata_d = merge_data;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY > 0) ? ST_WAIT : ST_EXECUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_EXECUTE: begin
        result_d = (err_s || is_store(op_q)) ? 32'h0000_0000 : load_data_s;
        err_d    = err_s;
        state_d  = ST_RESPOND;
      end
      ST_RESPOND: begin
        response_valid_d = 1'b1;
        read_data_d      = result_q;
        error_d          = err_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, capture and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      op_q             <= 4'd0;
      addr_q           <= 32'h0000_0000;
      wdata_q          <= 32'h0000_0000;
      mdata_q          <= 32'h0000_0000;
      result_q         <= 32'h0000_0000;
      err_q            <= 1'b0;
      response_valid_q <= 1'b0;
      read_data_q      <= 32'h0000_0000;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      mdata_q          <= mdata_d;
      result_q         <= result_d;
      err_q            <= err_d;
      response_valid_q <= response_valid_d;
      read_data_q      <= read_data_d;
      error_q          <= error_d;
    end
  end

  // Storage is deliberately unreset so it can be preloaded; reset forces IDLE, blocking writes.
  always_ff @(posedge clock) begin
    if (we_s) begin
      storage[idx_s] <= store_word_s;
    end
  end

  assign ready          = ready_s;
  assign response_valid = response_valid_q;
  assign read_data      = read_data_q;
  assign error          = error_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench: table of load/store vectors on a zero-latency unit plus
// timing and reset-abort sequences on a three-wait-state unit.
module tb_data_memory_unit;
  import data_memory_pkg::*;

  logic        clk;
  logic        rst0_n, req0, rdy0, rv0, err0;
  logic [3:0]  op0;
  logic [31:0] ad0, wd0, md0, rd0;
  logic        rst3_n, req3, rdy3, rv3, err3;
  logic [3:0]  op3;
  logic [31:0] ad3, wd3, md3, rd3;

  int checks = 0;
  int errors = 0;

  data_memory_unit #(.DEPTH(1024), .LATENCY(0)) u0 (
    .clock(clk), .reset(rst0_n), .request(req0), .ready(rdy0), .operation(op0),
    .address(ad0), .write_data(wd0), .merge_data(md0),
    .response_valid(rv0), .read_data(rd0), .error(err0));

  data_memory_unit #(.DEPTH(1024), .LATENCY(3)) u3 (
    .clock(clk), .reset(rst3_n), .request(req3), .ready(rdy3), .operation(op3),
    .address(ad3), .write_data(wd3), .merge_data(md3),
    .response_valid(rv3), .read_data(rd3), .error(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] md;
    logic [31:0] rd;
    logic        err;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic rq, input logic [3:0] op,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] md);
    if (k == 0) begin
      req0 = rq; op0 = op; ad0 = ad; wd0 = wd; md0 = md;
    end else begin
      req3 = rq; op3 = op; ad3 = ad; wd3 = wd; md3 = md;
    end
  endtask

  function automatic logic get_rv(input int k);
    return (k == 0) ? rv0 : rv3;
  endfunction

  // Issue one request from an idle unit; inputs change to junk after acceptance.
  task automatic run_access(input int k, input logic [3:0] op, input logic [31:0] ad,
                            input logic [31:0] wd, input logic [31:0] md,
                            output logic [31:0] rd, output logic er, output logic got);
    @(negedge clk);
    drive(k, 1'b1, op, ad, wd, md);
    @(negedge clk);
    drive(k, 1'b0, OP_SW, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    got = 1'b0; rd = 32'h0; er = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (!got) begin
        if (get_rv(k)) begin
          got = 1'b1;
          rd  = (k == 0) ? rd0 : rd3;
          er  = (k == 0) ? err0 : err3;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        got;
    int          seen;

    rst0_n = 1'b0; rst3_n = 1'b0;
    drive(0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, rdy0}, 32'h1);
    chk("reset_rv", {31'h0, rv0}, 32'h0);
    chk("reset_rdata", rd0, 32'h0);
    chk("reset_err", {31'h0, err0}, 32'h0);
    chk("reset_ready3", {31'h0, rdy3}, 32'h1);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // op, addr, write_data, merge_data, expected read_data, error, storage[0] afterwards
    vecs.push_back('{OP_LB,  32'h1,    32'h0,         32'h0,         32'hFFFF_FF99, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LBU, 32'h1,    32'h0,         32'h0,         32'h0000_0099, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LH,  32'h2,    32'h0,         32'h0,         32'hFFFF_AABB, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LHU, 32'h0,    32'h0,         32'h0,         32'h0000_8899, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LB,  32'h0,    32'h0,         32'h0,         32'hFFFF_FF88, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LBU, 32'h3,    32'h0,         32'h0,         32'h0000_00BB, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LW,  32'h0,    32'h0,         32'h0,         32'h8899_AABB, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LWL, 32'h1,    32'h0,         32'h1122_3344, 32'h99AA_BB44, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LWL, 32'h0,    32'h0,         32'h1122_3344, 32'h8899_AABB, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LWR, 32'h1,    32'h0,         32'h1122_3344, 32'h1122_8899, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_LWR, 32'h3,    32'h0,         32'h1122_3344, 32'h8899_AABB, 1'b0, 32'h8899_AABB});
    vecs.push_back('{OP_SWL, 32'h2,    32'hCCDD_EEFF, 32'h0,         32'h0,         1'b0, 32'h8899_CCDD});
    vecs.push_back('{OP_SWL, 32'h0,    32'hCCDD_EEFF, 32'h0,         32'h0,         1'b0, 32'hCCDD_EEFF});
    vecs.push_back('{OP_SWR, 32'h1,    32'hCCDD_EEFF, 32'h0,         32'h0,         1'b0, 32'hEEFF_AABB});
    vecs.push_back('{OP_SWR, 32'h3,    32'hCCDD_EEFF, 32'h0,         32'h0,         1'b0, 32'hCCDD_EEFF});
    vecs.push_back('{OP_SB,  32'h3,    32'h0000_00EE, 32'h0,         32'h0,         1'b0, 32'h8899_AAEE});
    vecs.push_back('{OP_SB,  32'h1,    32'h0000_00EE, 32'h0,         32'h0,         1'b0, 32'h88EE_AABB});
    vecs.push_back('{OP_SH,  32'h2,    32'h0000_CAFE, 32'h0,         32'h0,         1'b0, 32'h8899_CAFE});
    vecs.push_back('{OP_LW,  32'h2,    32'h0,         32'h0,         32'h0,         1'b1, 32'h8899_AABB});
    vecs.push_back('{OP_SH,  32'h1,    32'h0000_1234, 32'h0,         32'h0,         1'b1, 32'h8899_AABB});
    vecs.push_back('{OP_SW,  32'h1000, 32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'h8899_AABB});
    vecs.push_back('{OP_LW,  32'h1000, 32'h0,         32'h0,         32'h0,         1'b1, 32'h8899_AABB});
    vecs.push_back('{4'd7,   32'h0,    32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'h8899_AABB});
    vecs.push_back('{4'd13,  32'h0,    32'h1234_5678, 32'h0,         32'h0,         1'b1, 32'h8899_AABB});

    foreach (vecs[i]) begin
      run_access(0, OP_SW, 32'h0, 32'h8899_AABB, 32'h0, rd, er, got);
      chk($sformatf("v%0d_preload_err", i), {31'h0, er}, 32'h0);
      run_access(0, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].md, rd, er, got);
      chk($sformatf("v%0d_resp", i), {31'h0, got}, 32'h1);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_word", i), u0.storage[0], vecs[i].word);
    end

    // Store then load of another word returns the new data.
    run_access(0, OP_SW, 32'h14, 32'hDEAD_BEEF, 32'h0, rd, er, got);
    run_access(0, OP_LW, 32'h14, 32'h0, 32'h0, rd, er, got);
    chk("st_ld_rdata", rd, 32'hDEAD_BEEF);
    chk("st_ld_err", {31'h0, er}, 32'h0);

    // LATENCY=3 timing with request held high throughout.
    run_access(1, OP_SW, 32'h0, 32'h8899_AABB, 32'h0, rd, er, got);
    chk("l3_preload_resp", {31'h0, got}, 32'h1);
    @(negedge clk);
    drive(1, 1'b1, OP_LW, 32'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("l3_rv_c%0d", i), {31'h0, rv3}, {31'h0, (i == 6)});
      chk($sformatf("l3_ready_c%0d", i), {31'h0, rdy3}, {31'h0, (i >= 7)});
      if (i == 6) chk("l3_rdata", rd3, 32'h8899_AABB);
      if (i == 2) ad3 = 32'h4;
      if (i == 7) req3 = 1'b0;
    end

    // Reset during WAIT aborts a store.
    @(negedge clk);
    drive(1, 1'b1, OP_SW, 32'h0, 32'h1234_5678, 32'h0);
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    rst3_n = 1'b0;
    @(negedge clk);
    chk("abort_ready_in_reset", {31'h0, rdy3}, 32'h1);
    chk("abort_rv_in_reset", {31'h0, rv3}, 32'h0);
    rst3_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv3) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'h0);
    chk("abort_word", u3.storage[0], 32'h8899_AABB);
    chk("abort_ready", {31'h0, rdy3}, 32'h1);
    run_access(1, OP_LW, 32'h0, 32'h0, 32'h0, rd, er, got);
    chk("abort_reload_resp", {31'h0, got}, 32'h1);
    chk("abort_reload_rdata", rd, 32'h8899_AABB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
